// File: rtl/n64_vtiming_gen.sv
// N64 video-interface stream generator: 4-phase pixel bus (nDSYNC + sync nibble, then R/G/B).
// Latency: outputs are registered, 1 VCLK behind the internal pixel/line/field counters.
// Backpressure: none; free-running source. Optional colour bars via N64A_VTIMING_COLORBARS_EN.
module n64_vtiming_gen #(
    parameter int HS_WIDTH    = 57,
    parameter int CLAMP_START = 65,
    parameter int CLAMP_WIDTH = 28,
    parameter int H_ACT_START = 128,
    parameter int V_ACT_START = 18,
    parameter int VS_LINES    = 3
) (
    input  logic       VCLK,
    input  logic       RST,
    input  logic       vmode_i,
    input  logic       n64_480i_i,
    output logic       nDSYNC,
    output logic [6:0] D_o,
    output logic       field_o
);

    localparam logic [9:0] HS_W      = 10'(HS_WIDTH);
    localparam logic [9:0] CL_S      = 10'(CLAMP_START);
    localparam logic [9:0] CL_E      = 10'(CLAMP_START + CLAMP_WIDTH);
    localparam logic [9:0] HA_S      = 10'(H_ACT_START);
    localparam logic [9:0] HA_E      = 10'(H_ACT_START + 640);
    localparam logic [8:0] VA_S      = 9'(V_ACT_START);
    localparam logic [8:0] VA_E_NTSC = 9'(V_ACT_START + 240);
    localparam logic [8:0] VA_E_PAL  = 9'(V_ACT_START + 288);
    localparam logic [8:0] VS_L      = 9'(VS_LINES);

    logic [1:0] ph_q, ph_d;
    logic [9:0] h_q, h_d;
    logic [8:0] v_q, v_d;
    logic       field_q, field_d;
    logic       vmode_q, vmode_d;
    logic       i480_q, i480_d;
    logic       ndsync_q, ndsync_d;
    logic [6:0] d_q, d_d;
    logic       field_o_q;

    logic [9:0] h_tot, half;
    logic [8:0] v_tot, va_e;
    logic       vs_low, hs_low, clamp_low, active;
    logic       n_vs, n_hs, n_cl, n_cs;
    logic [2:0] bar_rgb;

    // Line/field geometry for the mode latched at the start of the current field.
    always_comb begin
        h_tot = vmode_q ? 10'd794 : 10'd773;
        half  = vmode_q ? 10'd397 : 10'd386;
        va_e  = vmode_q ? VA_E_PAL : VA_E_NTSC;
        // Only the even field of an interlaced pair is one line short.
        if (i480_q && !field_q)
            v_tot = vmode_q ? 9'd312 : 9'd262;
        else
            v_tot = vmode_q ? 9'd313 : 9'd263;
    end

    // Counter advance; mode inputs are captured on the edge that starts a new field.
    always_comb begin
        ph_d    = ph_q + 2'd1;
        h_d     = h_q;
        v_d     = v_q;
        field_d = field_q;
        vmode_d = vmode_q;
        i480_d  = i480_q;
        if (ph_q == 2'd3) begin
            if (h_q == h_tot - 10'd1) begin
                h_d = '0;
                if (v_q == v_tot - 9'd1) begin
                    v_d     = '0;
                    // Interlaced alternates odd/even; progressive is always even.
                    field_d = n64_480i_i & ~field_q;
                    vmode_d = vmode_i;
                    i480_d  = n64_480i_i;
                end else begin
                    v_d = v_q + 9'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

`ifdef N64A_VTIMING_COLORBARS_EN
    logic [2:0] bar_q, bar_d;
    logic [6:0] bar_px_q, bar_px_d;

    // Bar index steps every 80 active pixels; restarted just before the window opens.
    always_comb begin
        bar_d    = bar_q;
        bar_px_d = bar_px_q;
        if (ph_q == 2'd3) begin
            if (h_q == HA_S - 10'd1) begin
                bar_d    = '0;
                bar_px_d = '0;
            end else if (h_q >= HA_S && h_q < HA_E) begin
                if (bar_px_q == 7'd79) begin
                    bar_px_d = '0;
                    bar_d    = bar_q + 3'd1;
                end else begin
                    bar_px_d = bar_px_q + 7'd1;
                end
            end
        end
    end

    // Bar counter registers.
    always_ff @(posedge VCLK) begin
        if (RST) begin
            bar_q    <= '0;
            bar_px_q <= '0;
        end else begin
            bar_q    <= bar_d;
            bar_px_q <= bar_px_d;
        end
    end

    // White, yellow, cyan, green, magenta, red, blue, black as {R,G,B} on/off.
    assign bar_rgb = {~bar_q[1], ~bar_q[2], ~bar_q[0]};
`else
    assign bar_rgb = 3'b000;
`endif

    // Sync decode and phase multiplexing of the next bus word.
    always_comb begin
        ndsync_d = 1'b1;
        d_d      = 7'h00;
        if (field_q)
            vs_low = (v_q < VS_L);
        else
            vs_low = (v_q == 9'd0 && h_q >= half) ||
                     (v_q != 9'd0 && v_q < VS_L) ||
                     (v_q == VS_L && h_q < half);
        hs_low    = (h_q < HS_W);
        clamp_low = !vs_low && (h_q >= CL_S) && (h_q < CL_E);
        active    = (h_q >= HA_S) && (h_q < HA_E) && (v_q >= VA_S) && (v_q < va_e);
        n_vs      = ~vs_low;
        n_hs      = ~hs_low;
        n_cl      = ~clamp_low;
        n_cs      = n_vs ? n_hs : ~n_hs;
        case (ph_q)
            2'd0: begin
                ndsync_d = 1'b0;
                d_d      = {3'b000, n_vs, n_cl, n_hs, n_cs};
            end
            2'd1:    d_d = (active && bar_rgb[2]) ? 7'h7F : 7'h00;
            2'd2:    d_d = (active && bar_rgb[1]) ? 7'h7F : 7'h00;
            default: d_d = (active && bar_rgb[0]) ? 7'h7F : 7'h00;
        endcase
    end

    // State and output registers; reset restarts at pixel (0,0) of a fresh field.
    always_ff @(posedge VCLK) begin
        if (RST) begin
            ph_q      <= '0;
            h_q       <= '0;
            v_q       <= '0;
            field_q   <= n64_480i_i;
            vmode_q   <= vmode_i;
            i480_q    <= n64_480i_i;
            ndsync_q  <= 1'b1;
            d_q       <= 7'h0F;
            field_o_q <= n64_480i_i;
        end else begin
            ph_q      <= ph_d;
            h_q       <= h_d;
            v_q       <= v_d;
            field_q   <= field_d;
            vmode_q   <= vmode_d;
            i480_q    <= i480_d;
            ndsync_q  <= ndsync_d;
            d_q       <= d_d;
            field_o_q <= field_q;
        end
    end

    assign nDSYNC  = ndsync_q;
    assign D_o     = d_q;
    assign field_o = field_o_q;

endmodule

// File: tb/tb_n64_vtiming_gen.sv
// Directed bench for n64_vtiming_gen: full-line bus checks in NTSC/PAL, progressive/interlaced.
// Long vertical spans are skipped by pre-loading the line counter at the start of a line.
// Expected values come from a small per-pixel model of the sync/colour-bar rules.
module tb_n64_vtiming_gen;

    logic       VCLK = 1'b0;
    logic       RST;
    logic       vmode_i;
    logic       n64_480i_i;
    logic       nDSYNC;
    logic [6:0] D_o;
    logic       field_o;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cur_v = 0;
    int         cur_h = 0;
    logic [8:0] jump_v;

`ifdef N64A_VTIMING_COLORBARS_EN
    localparam bit CB_EN = 1'b1;
`else
    localparam bit CB_EN = 1'b0;
`endif

    n64_vtiming_gen dut (
        .VCLK       (VCLK),
        .RST        (RST),
        .vmode_i    (vmode_i),
        .n64_480i_i (n64_480i_i),
        .nDSYNC     (nDSYNC),
        .D_o        (D_o),
        .field_o    (field_o)
    );

    always #5 VCLK = ~VCLK;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s v=%0d h=%0d: observed %0h expected %0h", tag, cur_v, cur_h, obs, exp_v);
        end
    endtask

    function automatic logic [6:0] exp_sync(input int h, input int v, input bit odd, input bit pal);
        int half;
        bit vs_low, nv, nh, ncl, ncs;
        half = pal ? 397 : 386;
        if (odd) vs_low = (v < 3);
        else     vs_low = (v == 0 && h >= half) || (v == 1) || (v == 2) || (v == 3 && h < half);
        nv  = !vs_low;
        nh  = (h >= 57);
        ncl = !(!vs_low && h >= 65 && h < 93);
        ncs = nv ? nh : !nh;
        return {3'b000, nv, ncl, nh, ncs};
    endfunction

    function automatic logic [6:0] exp_rgb(input int h, input int v, input bit pal, input int p);
        logic [2:0] tbl [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
        int vend;
        int bar;
        vend = 18 + (pal ? 288 : 240);
        if (CB_EN && v >= 18 && v < vend && h >= 128 && h < 768) begin
            bar = (h - 128) / 80;
            return tbl[bar][3 - p] ? 7'h7F : 7'h00;
        end
        return 7'h00;
    endfunction

    // Checks one full line starting at its phase-0 word; ends with the counters at the next line's phase 0.
    task automatic check_line(input int v, input bit odd, input bit pal);
        int ht;
        ht = pal ? 794 : 773;
        for (int h = 0; h < ht; h++) begin
            cur_v = v;
            cur_h = h;
            @(negedge VCLK);
            chk("dsync_low", {6'd0, nDSYNC}, 7'd0);
            chk("sync_word", D_o, exp_sync(h, v, odd, pal));
            if (h == 0) chk("field", {6'd0, field_o}, {6'd0, odd});
            for (int p = 1; p < 4; p++) begin
                @(negedge VCLK);
                chk("dsync_high", {6'd0, nDSYNC}, 7'd1);
                chk("rgb", D_o, exp_rgb(h, v, pal, p));
            end
        end
    endtask

    // Pre-loads the line counter while the counters sit at phase 0 of pixel 0.
    task automatic jump(input logic [8:0] target);
        jump_v = target;
        force dut.v_q = jump_v;
        @(posedge VCLK);
        #1;
        release dut.v_q;
    endtask

    initial begin
        RST        = 1'b1;
        vmode_i    = 1'b0;
        n64_480i_i = 1'b0;
        jump_v     = '0;

        // Reset state, progressive NTSC sampled during reset
        repeat (3) @(posedge VCLK);
        @(negedge VCLK);
        cur_v = -1; cur_h = -1;
        chk("rst_dsync", {6'd0, nDSYNC}, 7'd1);
        chk("rst_d", D_o, 7'h0F);
        chk("rst_field", {6'd0, field_o}, 7'd0);
        RST = 1'b0;

        // NTSC progressive: vsync fall at h=386 on line 0, rise at h=386 on line 3
        for (int v = 0; v < 5; v++) check_line(v, 1'b0, 1'b0);
        // Last line of a 263-line field, then wrap into another even field
        jump(9'd262);
        check_line(262, 1'b0, 1'b0);
        check_line(0, 1'b0, 1'b0);

        // Mid-field switch to PAL interlaced: current field still 773 px and 263 lines
        vmode_i    = 1'b1;
        n64_480i_i = 1'b1;
        jump(9'd262);
        check_line(262, 1'b0, 1'b0);

        // PAL odd field: vsync falls with hsync; first active line
        check_line(0, 1'b1, 1'b1);
        jump(9'd18);
        check_line(18, 1'b1, 1'b1);
        // Odd field is 313 lines, even is 312
        jump(9'd312);
        check_line(312, 1'b1, 1'b1);
        check_line(0, 1'b0, 1'b1);
        jump(9'd311);
        check_line(311, 1'b0, 1'b1);
        check_line(0, 1'b1, 1'b1);

        // Reset at line 50, pixel 300, phase 2
        jump(9'd50);
        repeat (1201) @(posedge VCLK);
        #1;
        RST = 1'b1;
        @(posedge VCLK);
        @(negedge VCLK);
        cur_v = 50; cur_h = 300;
        chk("midrst_dsync", {6'd0, nDSYNC}, 7'd1);
        chk("midrst_d", D_o, 7'h0F);
        chk("midrst_field", {6'd0, field_o}, 7'd1);
        RST = 1'b0;
        @(negedge VCLK);
        cur_v = 0; cur_h = 0;
        chk("restart_dsync", {6'd0, nDSYNC}, 7'd0);
        chk("restart_word", D_o, 7'h05);
        chk("restart_field", {6'd0, field_o}, 7'd1);
        for (int p = 1; p < 4; p++) begin
            @(negedge VCLK);
            chk("restart_dsync_hi", {6'd0, nDSYNC}, 7'd1);
            chk("restart_rgb", D_o, 7'h00);
        end
        @(negedge VCLK);
        cur_h = 1;
        chk("restart_next_dsync", {6'd0, nDSYNC}, 7'd0);
        chk("restart_next_word", D_o, 7'h05);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
